// File: rtl/aes_sbox_pkg.sv
// AES forward/inverse S-box tables and per-byte lookup helpers.
// The inverse table is only compiled in when SBOX_INV_EN is defined.
package aes_sbox_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam aes_byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic aes_byte_t sbox_fwd(input aes_byte_t b);
        return SBOX_FWD[b];
    endfunction

`ifdef SBOX_INV_EN
    localparam aes_byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_byte_t sbox_inv(input aes_byte_t b);
        return SBOX_INV[b];
    endfunction
`endif

endpackage

// File: rtl/sbox_byte.sv
// Single-lane combinational S-box lookup. With SBOX_INV_EN defined, i_inv
// selects the inverse table; otherwise the forward table is always used.
module sbox_byte
    import aes_sbox_pkg::*;
(
    input  aes_byte_t i_byte,
    input  logic      i_inv,
    output aes_byte_t o_byte
);

`ifdef SBOX_INV_EN
    assign o_byte = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_byte       = sbox_fwd(i_byte);
`endif

endmodule

// File: rtl/sbox_lane_array.sv
// Pipelined LANES-wide AES S-box unit with valid/ready on both sides.
// Inverse substitution is available when SBOX_INV_EN is defined.
module sbox_lane_array
    import aes_sbox_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [15:0]        xfer_count
);

    logic [8*LANES-1:0] w_sub;
    logic [STAGES-1:0]  w_rdy;
    logic               w_acc;
    logic [STAGES-1:0]  r_vld;
    logic [8*LANES-1:0] r_data [STAGES];
    logic [TAG_W-1:0]   r_tag  [STAGES];
    logic [15:0]        r_xfer_count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_byte u_lane (
            .i_byte (in_data[8*g +: 8]),
            .i_inv  (in_inv),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Stage k may load if any slot from k to the output is free, or the
    // output is being drained; computed flat to avoid a combinational chain.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_rdy[k] = out_ready;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k && !r_vld[j]) w_rdy[k] = 1'b1;
            end
        end
    end

    assign in_ready = !reset && !flush && w_rdy[0];
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            // Stage 0: lookup result registered per accepted transfer
            if (flush)         r_vld[0] <= 1'b0;
            else if (w_rdy[0]) r_vld[0] <= w_acc;
            if (w_acc) begin
                r_data[0] <= w_sub;
                r_tag[0]  <= in_tag;
            end
            // Stages 1..STAGES-1: pure delay
            for (int k = 1; k < STAGES; k++) begin
                if (flush)         r_vld[k] <= 1'b0;
                else if (w_rdy[k]) r_vld[k] <= r_vld[k-1];
                if (w_rdy[k] && r_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       r_xfer_count <= '0;
        else if (out_valid && out_ready) r_xfer_count <= r_xfer_count + 16'd1;
    end

    assign out_valid  = r_vld[STAGES-1];
    assign out_data   = r_data[STAGES-1];
    assign out_tag    = r_tag[STAGES-1];
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_sbox_lane_array.sv
// Directed bench for sbox_lane_array: three instances with STAGES = 1, 2, 3.
// Inverse-mode expectations depend on whether SBOX_INV_EN is defined.
module tb_sbox_lane_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        in_inv    [3];
    logic [3:0]  in_tag    [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic [3:0]  out_tag   [3];
    logic [15:0] xfer      [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sbox_lane_array #(.LANES(4), .STAGES(k + 1), .TAG_W(4)) u_dut (
            .clock      (clk),
            .reset      (rst),
            .flush      (flush[k]),
            .in_valid   (in_valid[k]),
            .in_ready   (in_ready[k]),
            .in_data    (in_data[k]),
            .in_inv     (in_inv[k]),
            .in_tag     (in_tag[k]),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .out_data   (out_data[k]),
            .out_tag    (out_tag[k]),
            .xfer_count (xfer[k])
        );
    end

`ifdef SBOX_INV_EN
    localparam logic [31:0] EXP_INV_A  = 32'h00010253;
    localparam logic [31:0] EXP_INV_16 = 32'h525252FF;
`else
    localparam logic [31:0] EXP_INV_A  = 32'hFB10F555;
    localparam logic [31:0] EXP_INV_16 = 32'h63636347;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer through the STAGES=1 instance with out_ready held high.
    task automatic do_one(input string name, input logic [31:0] d, input logic inv,
                          input logic [3:0] tag, input logic [31:0] exp, input logic [15:0] cnt);
        in_valid[0] = 1'b1; in_data[0] = d; in_inv[0] = inv; in_tag[0] = tag; out_ready[0] = 1'b1;
        #1 chk({name, " in_ready"}, 32'(in_ready[0]), 32'd1);
        tick();
        in_valid[0] = 1'b0;
        chk({name, " out_valid"}, 32'(out_valid[0]), 32'd1);
        chk({name, " out_data"}, out_data[0], exp);
        chk({name, " out_tag"}, 32'(out_tag[0]), 32'(tag));
        tick();
        chk({name, " xfer_count"}, 32'(xfer[0]), 32'(cnt));
        chk({name, " drained"}, 32'(out_valid[0]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0;
            in_inv[k] = 1'b0; in_tag[k] = '0; out_ready[k] = 1'b0;
        end
        tick();
        tick();
        chk("rst in_ready", 32'(in_ready[0]), 32'd0);
        chk("rst out_valid", 32'(out_valid[2]), 32'd0);
        chk("rst out_data", out_data[0], 32'd0);
        chk("rst out_tag", 32'(out_tag[1]), 32'd0);
        chk("rst xfer", 32'(xfer[0]), 32'd0);
        rst = 1'b0;
        #1 chk("post-rst in_ready", 32'(in_ready[0]), 32'd1);

        do_one("fwd", 32'h00010253, 1'b0, 4'd5, 32'h637C77ED, 16'd1);
        do_one("inv", 32'h637C77ED, 1'b1, 4'd6, EXP_INV_A, 16'd2);
        do_one("inv16", 32'h00000016, 1'b1, 4'd7, EXP_INV_16, 16'd3);

        // Flush with out_ready high on STAGES=1: output completes and counts
        in_valid[0] = 1'b1; in_data[0] = 32'h00010253; in_inv[0] = 1'b0; out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        chk("s1 held valid", 32'(out_valid[0]), 32'd1);
        flush[0] = 1'b1; out_ready[0] = 1'b1;
        #1 chk("s1 flush in_ready", 32'(in_ready[0]), 32'd0);
        tick();
        flush[0] = 1'b0;
        chk("s1 flush emptied", 32'(out_valid[0]), 32'd0);
        chk("s1 flush counted", 32'(xfer[0]), 32'd4);

        // STAGES=3: 10 back-to-back transfers, alternating mode
        out_ready[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                in_valid[2] = 1'b1;
                in_data[2]  = c[0] ? 32'h637C77ED : 32'h00010253;
                in_inv[2]   = c[0];
                in_tag[2]   = c[3:0];
                #1 chk("s3 in_ready", 32'(in_ready[2]), 32'd1);
            end else begin
                in_valid[2] = 1'b0;
            end
            tick();
            if (c >= 2) begin
                chk("s3 out_valid", 32'(out_valid[2]), 32'd1);
                chk("s3 out_data", out_data[2], c[0] ? EXP_INV_A : 32'h637C77ED);
                chk("s3 out_tag", 32'(out_tag[2]), 32'(c - 2));
            end else begin
                chk("s3 latency", 32'(out_valid[2]), 32'd0);
            end
        end
        tick();
        chk("s3 drained", 32'(out_valid[2]), 32'd0);
        chk("s3 xfer", 32'(xfer[2]), 32'd10);

        // STAGES=2 backpressure
        in_valid[1] = 1'b1; in_data[1] = 32'h00010253; in_inv[1] = 1'b0; in_tag[1] = 4'd1;
        tick();
        chk("s2 one slot free", 32'(in_ready[1]), 32'd1);
        in_data[1] = 32'h00000016; in_tag[1] = 4'd2;
        tick();
        in_data[1] = 32'hFFFFFFFF; in_tag[1] = 4'd3;
        #1 chk("s2 full in_ready", 32'(in_ready[1]), 32'd0);
        chk("s2 stall valid", 32'(out_valid[1]), 32'd1);
        chk("s2 stall data", out_data[1], 32'h637C77ED);
        tick();
        chk("s2 stable data", out_data[1], 32'h637C77ED);
        chk("s2 stable tag", 32'(out_tag[1]), 32'd1);
        chk("s2 stall xfer", 32'(xfer[1]), 32'd0);
        in_valid[1] = 1'b0; out_ready[1] = 1'b1;
        tick();
        chk("s2 drain2 data", out_data[1], 32'h63636347);
        chk("s2 drain2 tag", 32'(out_tag[1]), 32'd2);
        chk("s2 drain1 xfer", 32'(xfer[1]), 32'd1);
        tick();
        chk("s2 drained", 32'(out_valid[1]), 32'd0);
        chk("s2 drain xfer", 32'(xfer[1]), 32'd2);

        // STAGES=2 flush with two in flight
        out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 32'h00010253; in_tag[1] = 4'd4;
        tick();
        in_tag[1] = 4'd5;
        tick();
        chk("s2 inflight", 32'(out_valid[1]), 32'd1);
        flush[1] = 1'b1; in_tag[1] = 4'd6;
        #1 chk("s2 flush in_ready", 32'(in_ready[1]), 32'd0);
        tick();
        flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b1;
        #1 chk("s2 flush valid", 32'(out_valid[1]), 32'd0);
        chk("s2 flush xfer", 32'(xfer[1]), 32'd2);
        chk("s2 post-flush in_ready", 32'(in_ready[1]), 32'd1);
        tick();
        chk("s2 flush no ghost", 32'(out_valid[1]), 32'd0);
        chk("s2 flush xfer2", 32'(xfer[1]), 32'd2);

        // Reset mid-stream on STAGES=1, then wrap the counter
        in_valid[0] = 1'b1; in_data[0] = 32'h00010253; out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        chk("mid inflight", 32'(out_valid[0]), 32'd1);
        rst = 1'b1;
        #1 chk("mid rst valid", 32'(out_valid[0]), 32'd0);
        chk("mid rst xfer", 32'(xfer[0]), 32'd0);
        chk("mid rst in_ready", 32'(in_ready[0]), 32'd0);
        tick();
        rst = 1'b0; out_ready[0] = 1'b1;
        tick();
        chk("mid discarded", 32'(out_valid[0]), 32'd0);
        chk("mid xfer", 32'(xfer[0]), 32'd0);
        in_valid[0] = 1'b1;
        repeat (65535) tick();
        in_valid[0] = 1'b0;
        tick();
        chk("preload xfer", 32'(xfer[0]), 32'h0000FFFF);
        chk("preload drained", 32'(out_valid[0]), 32'd0);
        do_one("wrap", 32'h00010253, 1'b0, 4'd9, 32'h637C77ED, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
